// File: rtl/vga_rect_filler.sv
// vga_rect_filler: paints a clipped rectangle through the video card's X/Y/PIXEL opcode bus.
// Optional read-modify-write XOR painting is enabled by defining VGA_FILL_XOR_EN.
module vga_rect_filler #(
  parameter int IN_WIDTH  = 320,
  parameter int IN_HEIGHT = 240
) (
  input  logic        CLK_mips,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  input  logic [8:0]  cmd_w,
  input  logic [8:0]  cmd_h,
  input  logic [1:0]  cmd_color,
  output logic        busy,
  output logic        done,
  output logic [1:0]  vga_opcode,
  output logic        vga_we,
  output logic [31:0] vga_write_data,
  input  logic [31:0] vga_read_data
);
  localparam logic [9:0] W_MAX = 10'(IN_WIDTH);
  localparam logic [9:0] H_MAX = 10'(IN_HEIGHT);
`ifdef VGA_FILL_XOR_EN
  typedef enum logic [2:0] {IDLE, SET_Y, SET_X, RD, RDW, PUT, DONE} state_t;
  logic [1:0] p;
`else
  typedef enum logic [2:0] {IDLE, SET_Y, SET_X, PUT, DONE} state_t;
`endif
  state_t state;
  logic [8:0] x0, cx, cy;
  logic [9:0] xe, ye, xs, ys, cx1, cy1;
  logic [1:0] color, pix;
  logic degen, unused_rd;
  assign unused_rd = ^vga_read_data;
  assign xs = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign ys = {1'b0, cmd_y} + {1'b0, cmd_h};
  assign cx1 = {1'b0, cx} + 10'd1;
  assign cy1 = {1'b0, cy} + 10'd1;
  assign degen = cmd_w == 9'd0 || cmd_h == 9'd0 || {1'b0, cmd_x} >= W_MAX || {1'b0, cmd_y} >= H_MAX;
`ifdef VGA_FILL_XOR_EN
  assign pix = p ^ color;
`else
  assign pix = color;
`endif
  always_ff @(posedge CLK_mips or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      x0 <= '0;
      cx <= '0;
      cy <= '0;
      xe <= '0;
      ye <= '0;
      color <= '0;
`ifdef VGA_FILL_XOR_EN
      p <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          x0 <= cmd_x;
          cx <= cmd_x;
          cy <= cmd_y;
          xe <= xs > W_MAX ? W_MAX : xs;
          ye <= ys > H_MAX ? H_MAX : ys;
          color <= cmd_color;
          state <= degen ? DONE : SET_Y;
        end
        SET_Y: state <= SET_X;
`ifdef VGA_FILL_XOR_EN
        SET_X: state <= RD;
        RD: state <= RDW;
        RDW: begin
          p <= vga_read_data[1:0];
          state <= PUT;
        end
`else
        SET_X: state <= PUT;
`endif
        PUT: if (cx1 < xe) begin
          cx <= cx + 9'd1;
          state <= SET_X;
        end else if (cy1 < ye) begin
          cy <= cy + 9'd1;
          cx <= x0;
          state <= SET_Y;
        end else begin
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    cmd_ready = state == IDLE;
    busy = state != IDLE;
    done = state == DONE;
    vga_we = state == SET_Y || state == SET_X || state == PUT;
`ifdef VGA_FILL_XOR_EN
    vga_opcode = state == SET_Y ? 2'b10 : state == SET_X ? 2'b01 :
                 (state == PUT || state == RD || state == RDW) ? 2'b11 : 2'b00;
`else
    vga_opcode = state == SET_Y ? 2'b10 : state == SET_X ? 2'b01 : state == PUT ? 2'b11 : 2'b00;
`endif
    vga_write_data = state == SET_Y ? {23'b0, cy} : state == SET_X ? {23'b0, cx} :
                     state == PUT ? {30'b0, pix} : 32'b0;
  end
endmodule
